// File: rtl/ddr_ring_sched.sv
// ddr_ring_sched: schedules S2MM (write) and MM2S (read) datamover commands
// over a ring of fixed-size DDR chunks, with one outstanding command total.
// Optional build macro RING_SCHED_TAG_CHECK_EN: when defined, a status whose
// tag field [3:0] differs from the outstanding command's tag is an error.
module ddr_ring_sched #(
    parameter int unsigned CHUNK_BYTES = 4096,
    parameter int unsigned RING_CHUNKS = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        rd_req,
    output logic [71:0] S_AXIS_S2MM_CMD_tdata,
    output logic        S_AXIS_S2MM_CMD_tvalid,
    input  logic        S_AXIS_S2MM_CMD_tready,
    input  logic [7:0]  M_AXIS_S2MM_STS_tdata,
    input  logic        M_AXIS_S2MM_STS_tvalid,
    output logic        M_AXIS_S2MM_STS_tready,
    output logic [71:0] S_AXIS_MM2S_CMD_tdata,
    output logic        S_AXIS_MM2S_CMD_tvalid,
    input  logic        S_AXIS_MM2S_CMD_tready,
    input  logic [7:0]  M_AXIS_MM2S_STS_tdata,
    input  logic        M_AXIS_MM2S_STS_tvalid,
    output logic        M_AXIS_MM2S_STS_tready,
    output logic [8:0]  fill,
    output logic        full,
    output logic        err
);

    localparam int unsigned PW      = $clog2(RING_CHUNKS);
    localparam logic [8:0]  RING_N  = 9'(RING_CHUNKS);
    localparam logic [31:0] CHUNK32 = 32'(CHUNK_BYTES);

    typedef enum logic [2:0] {
        IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, ERROR
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [8:0]     fill_q, fill_d;
    logic [3:0]     tag_q, tag_d;
    logic           rd_pend_q, rd_pend_d;
    logic           err_q, err_d;
    logic           last_wr_q, last_wr_d;
    logic [71:0]    cmd_q, cmd_d;

    logic wr_pending, rd_pending, grant_wr, grant_rd;
    logic wr_cmd_hs, rd_cmd_hs, wr_sts_hs, rd_sts_hs;
    logic wr_sts_good, rd_sts_good, tag_ok_wr, tag_ok_rd;

    // Command word: fixed BTT, INCR, EOF; address from ring pointer; tag on top.
    function automatic logic [71:0] mk_cmd(input logic [PW-1:0] ptr, input logic [3:0] tag);
        logic [31:0] addr;
        addr = BASE_ADDR + ({{(32-PW){1'b0}}, ptr} * CHUNK32);
        return {4'h0, tag, addr, 1'b0, 1'b1, 6'h00, 1'b1, 23'(CHUNK_BYTES)};
    endfunction

`ifdef RING_SCHED_TAG_CHECK_EN
    assign tag_ok_wr = (M_AXIS_S2MM_STS_tdata[3:0] == cmd_q[67:64]);
    assign tag_ok_rd = (M_AXIS_MM2S_STS_tdata[3:0] == cmd_q[67:64]);
`else
    // Tag field is ignored in this build.
    logic unused_sts_tags;
    assign unused_sts_tags = ^{M_AXIS_S2MM_STS_tdata[3:0], M_AXIS_MM2S_STS_tdata[3:0]};
    assign tag_ok_wr = 1'b1;
    assign tag_ok_rd = 1'b1;
`endif

    assign full        = (fill_q == RING_N);
    assign fill        = fill_q;
    assign err         = err_q;
    assign wr_pending  = enable && !full;
    assign rd_pending  = rd_pend_q && (fill_q != 9'd0);
    // Round robin: on contention the direction not granted last wins.
    assign grant_wr    = wr_pending && (!rd_pending || !last_wr_q);
    assign grant_rd    = rd_pending && (!wr_pending ||  last_wr_q);
    assign wr_cmd_hs   = (state_q == ISSUE_WR) && S_AXIS_S2MM_CMD_tready;
    assign rd_cmd_hs   = (state_q == ISSUE_RD) && S_AXIS_MM2S_CMD_tready;
    assign wr_sts_hs   = (state_q == WAIT_WR)  && M_AXIS_S2MM_STS_tvalid;
    assign rd_sts_hs   = (state_q == WAIT_RD)  && M_AXIS_MM2S_STS_tvalid;
    assign wr_sts_good = M_AXIS_S2MM_STS_tdata[7] && (M_AXIS_S2MM_STS_tdata[6:4] == 3'b000) && tag_ok_wr;
    assign rd_sts_good = M_AXIS_MM2S_STS_tdata[7] && (M_AXIS_MM2S_STS_tdata[6:4] == 3'b000) && tag_ok_rd;

    // FSM state register; reset drops any in-flight command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (grant_wr) state_d = ISSUE_WR;
                      else if (grant_rd) state_d = ISSUE_RD;
            ISSUE_WR: if (wr_cmd_hs) state_d = WAIT_WR;
            WAIT_WR:  if (wr_sts_hs) state_d = wr_sts_good ? IDLE : ERROR;
            ISSUE_RD: if (rd_cmd_hs) state_d = WAIT_RD;
            WAIT_RD:  if (rd_sts_hs) state_d = rd_sts_good ? IDLE : ERROR;
            ERROR:    state_d = ERROR;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake strobes decoded from state only.
    always_comb begin
        S_AXIS_S2MM_CMD_tvalid = (state_q == ISSUE_WR);
        S_AXIS_MM2S_CMD_tvalid = (state_q == ISSUE_RD);
        M_AXIS_S2MM_STS_tready = (state_q == WAIT_WR);
        M_AXIS_MM2S_STS_tready = (state_q == WAIT_RD);
        S_AXIS_S2MM_CMD_tdata  = cmd_q;
        S_AXIS_MM2S_CMD_tdata  = cmd_q;
    end

    // Ring bookkeeping: pointers, fill, tag, pending read, error, command latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        tag_d     = tag_q;
        rd_pend_d = rd_pend_q;
        err_d     = err_q;
        last_wr_d = last_wr_q;
        cmd_d     = cmd_q;
        if (state_q == IDLE && (grant_wr || grant_rd)) begin
            cmd_d     = mk_cmd(grant_wr ? wr_ptr_q : rd_ptr_q, tag_q);
            last_wr_d = grant_wr;
        end
        if (wr_cmd_hs || rd_cmd_hs) tag_d = tag_q + 4'd1;
        if (rd_cmd_hs)   rd_pend_d = 1'b0;
        else if (rd_req) rd_pend_d = 1'b1;
        if (wr_sts_hs && wr_sts_good && fill_q != RING_N) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = fill_q + 9'd1;
        end
        if (rd_sts_hs && rd_sts_good && fill_q != 9'd0) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            fill_d   = fill_q - 9'd1;
        end
        if ((wr_sts_hs && !wr_sts_good) || (rd_sts_hs && !rd_sts_good)) err_d = 1'b1;
    end

    // Bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            tag_q     <= '0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b0;
            cmd_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            tag_q     <= tag_d;
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
            last_wr_q <= last_wr_d;
            cmd_q     <= cmd_d;
        end
    end

endmodule

// File: tb/tb_ddr_ring_sched.sv
// Bench for ddr_ring_sched: directed scenarios plus randomized command mix,
// checked against a chunk-ring reference model.
module tb_ddr_ring_sched;
    localparam int CB = 4096;
    localparam int RC = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, rd_req = 1'b0;
    logic [71:0] s2mm_cmd, mm2s_cmd;
    logic s2mm_cv, mm2s_cv, s2mm_cr = 1'b0, mm2s_cr = 1'b0;
    logic [7:0] s2mm_sd = 8'h0, mm2s_sd = 8'h0;
    logic s2mm_sv = 1'b0, mm2s_sv = 1'b0, s2mm_sr, mm2s_sr;
    logic [8:0] fill;
    logic full, err;

    int errors = 0, checks = 0;

    // Reference model: ring of chunks seen as counters.
    int m_wr, m_rd, m_fill, m_tag;
    bit m_rd_pend, m_err, m_last_wr;

    ddr_ring_sched #(.CHUNK_BYTES(CB), .RING_CHUNKS(RC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .rd_req(rd_req),
        .S_AXIS_S2MM_CMD_tdata(s2mm_cmd), .S_AXIS_S2MM_CMD_tvalid(s2mm_cv), .S_AXIS_S2MM_CMD_tready(s2mm_cr),
        .M_AXIS_S2MM_STS_tdata(s2mm_sd), .M_AXIS_S2MM_STS_tvalid(s2mm_sv), .M_AXIS_S2MM_STS_tready(s2mm_sr),
        .S_AXIS_MM2S_CMD_tdata(mm2s_cmd), .S_AXIS_MM2S_CMD_tvalid(mm2s_cv), .S_AXIS_MM2S_CMD_tready(mm2s_cr),
        .M_AXIS_MM2S_STS_tdata(mm2s_sd), .M_AXIS_MM2S_STS_tvalid(mm2s_sv), .M_AXIS_MM2S_STS_tready(mm2s_sr),
        .fill(fill), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] exp_cmd(input int ptr, input int tag);
        logic [31:0] a;
        a = BASE + 32'(ptr * CB);
        return {4'h0, 4'(tag), a, 1'b0, 1'b1, 6'h00, 1'b1, 23'(CB)};
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_fill = 0; m_tag = 0;
        m_rd_pend = 0; m_err = 0; m_last_wr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; enable = 1'b0; rd_req = 1'b0;
        s2mm_cr = 0; mm2s_cr = 0; s2mm_sv = 0; mm2s_sv = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic pulse_rd();
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        if (!m_rd_pend) m_rd_pend = 1;
    endtask

    // One full command: grant, handshake after 'hold' stall cycles, status
    // after 'sdly' cycles. Optionally pulses rd_req while waiting for status.
    task automatic run_cmd(input int hold, input int sdly, input bit ovr, input logic [7:0] ovr_sts,
                           input bit rdp, input bit next_en, output bit was_wr);
        bit wr_p, rd_p, exp_wr, good;
        int n, ctag;
        logic [71:0] c0, c;
        logic [7:0] sts;
        wr_p = enable && (m_fill < RC);
        rd_p = m_rd_pend && (m_fill > 0);
        exp_wr = wr_p && (!rd_p || !m_last_wr);
        was_wr = exp_wr;
        n = 0;
        while (!s2mm_cv && !mm2s_cv && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin
            errors++; $display("FAIL cmd_timeout: no tvalid within 20 cycles, want %s", exp_wr ? "write" : "read");
            return;
        end
        checks++;
        if ({s2mm_cv, mm2s_cv} !== (exp_wr ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL grant: valids=%b want %b", {s2mm_cv, mm2s_cv}, exp_wr ? 2'b10 : 2'b01);
            return;
        end
        c0 = exp_wr ? s2mm_cmd : mm2s_cmd;
        checks++;
        if (c0 !== exp_cmd(exp_wr ? m_wr : m_rd, m_tag)) begin
            errors++; $display("FAIL cmd_data: got %h want %h", c0, exp_cmd(exp_wr ? m_wr : m_rd, m_tag));
        end
        repeat (hold) begin
            @(negedge clk);
            c = exp_wr ? s2mm_cmd : mm2s_cmd;
            checks++;
            if ((exp_wr ? s2mm_cv : mm2s_cv) !== 1'b1 || c !== c0) begin
                errors++; $display("FAIL cmd_hold: valid=%b data=%h want 1/%h", exp_wr ? s2mm_cv : mm2s_cv, c, c0);
            end
        end
        if (exp_wr) s2mm_cr = 1'b1; else mm2s_cr = 1'b1;
        @(negedge clk);
        s2mm_cr = 1'b0; mm2s_cr = 1'b0;
        ctag = m_tag;
        m_tag = (m_tag + 1) % 16;
        m_last_wr = exp_wr;
        if (!exp_wr) m_rd_pend = 0;
        checks++;
        if (s2mm_cv !== 1'b0 || mm2s_cv !== 1'b0) begin
            errors++; $display("FAIL cmd_drop: valids=%b want 00", {s2mm_cv, mm2s_cv});
        end
        if (rdp) pulse_rd();
        repeat (sdly) @(negedge clk);
        checks++;
        if ({s2mm_sr, mm2s_sr} !== (exp_wr ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL sts_ready: got %b want %b", {s2mm_sr, mm2s_sr}, exp_wr ? 2'b10 : 2'b01);
        end
        sts = ovr ? ovr_sts : {1'b1, 3'b000, 4'(ctag)};
        if (exp_wr) begin s2mm_sd = sts; s2mm_sv = 1'b1; end
        else begin mm2s_sd = sts; mm2s_sv = 1'b1; end
        @(negedge clk);
        s2mm_sv = 1'b0; mm2s_sv = 1'b0;
        enable = next_en;
        good = sts[7] && (sts[6:4] == 3'b000);
`ifdef RING_SCHED_TAG_CHECK_EN
        good = good && (sts[3:0] == 4'(ctag));
`endif
        if (!good) m_err = 1;
        else if (exp_wr) begin m_wr = (m_wr + 1) % RC; m_fill++; end
        else begin m_rd = (m_rd + 1) % RC; m_fill--; end
        checks++;
        if (fill !== 9'(m_fill) || full !== (m_fill == RC)) begin
            errors++; $display("FAIL fill: got %0d full=%b want %0d full=%b", fill, full, m_fill, m_fill == RC);
        end
        checks++;
        if (err !== m_err) begin
            errors++; $display("FAIL err: got %b want %b", err, m_err);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (s2mm_cv || mm2s_cv || s2mm_sr || mm2s_sr || fill !== 9'(m_fill) || err !== m_err) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL %s: %0d cycles with activity (fill=%0d err=%b, want fill=%0d err=%b)",
                               name, bad, fill, err, m_fill, m_err);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({s2mm_cv, mm2s_cv, s2mm_sr, mm2s_sr, full, err} !== 6'b0 || fill !== 9'd0) begin
            errors++; $display("FAIL reset_state: v=%b%b r=%b%b full=%b err=%b fill=%0d want all 0",
                               s2mm_cv, mm2s_cv, s2mm_sr, mm2s_sr, full, err, fill);
        end
        do_reset();
        expect_quiet("idle_after_reset", 8);
    endtask

    task automatic test_writes();
        bit w;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) run_cmd(0, 5, 0, 8'h0, 0, i < 3, w);
        expect_quiet("writes_stop", 5);
    endtask

    task automatic test_full();
        bit w;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < RC; i++) run_cmd($urandom_range(0, 2), $urandom_range(0, 3), 0, 8'h0, 0, 1'b1, w);
        expect_quiet("no_17th_write", 20);
        pulse_rd();
        run_cmd(0, 1, 0, 8'h0, 0, 1'b1, w);
        checks++;
        if (w !== 1'b0) begin errors++; $display("FAIL full_read_grant: got write want read"); end
        run_cmd(0, 1, 0, 8'h0, 0, 1'b0, w);
    endtask

    task automatic test_round_robin();
        bit w1, w2, w3, w;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) run_cmd(0, 0, 0, 8'h0, 0, i < 2, w);
        pulse_rd();
        enable = 1'b1;
        run_cmd(0, 1, 0, 8'h0, 1, 1'b1, w1);
        run_cmd(0, 1, 0, 8'h0, 1, 1'b1, w2);
        run_cmd(0, 1, 0, 8'h0, 0, 1'b0, w3);
        checks++;
        if ({w1, w2, w3} !== 3'b010) begin
            errors++; $display("FAIL rr_sequence: got wr-flags %b want 010 (R,W,R)", {w1, w2, w3});
        end
    endtask

    task automatic test_hold();
        bit w;
        do_reset();
        enable = 1'b1;
        run_cmd(10, 2, 0, 8'h0, 0, 1'b0, w);
    endtask

    task automatic test_error();
        bit w;
        do_reset();
        enable = 1'b1;
        run_cmd(0, 0, 0, 8'h0, 0, 1'b1, w);
        run_cmd(0, 0, 0, 8'h0, 0, 1'b1, w);
        run_cmd(0, 2, 1, 8'hC0, 0, 1'b1, w);
        pulse_rd();
        expect_quiet("error_blocks", 20);
    endtask

    task automatic test_tag();
        bit w;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) run_cmd(0, 0, 0, 8'h0, 0, 1'b1, w);
        run_cmd(0, 1, 1, 8'h85, 0, 1'b0, w);
        expect_quiet("after_tag_status", 5);
    endtask

    task automatic test_reset_mid();
        bit w;
        int n = 0;
        do_reset();
        enable = 1'b1;
        run_cmd(0, 0, 0, 8'h0, 0, 1'b1, w);
        run_cmd(0, 0, 0, 8'h0, 0, 1'b1, w);
        while (!s2mm_cv && n < 20) begin @(negedge clk); n++; end
        s2mm_cr = 1'b1;
        @(negedge clk);
        s2mm_cr = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({s2mm_cv, mm2s_cv, s2mm_sr, mm2s_sr, full, err} !== 6'b0 || fill !== 9'd0) begin
            errors++; $display("FAIL reset_mid: v=%b%b r=%b%b full=%b err=%b fill=%0d want all 0",
                               s2mm_cv, mm2s_cv, s2mm_sr, mm2s_sr, full, err, fill);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        enable = 1'b1;
        run_cmd(0, 0, 0, 8'h0, 0, 1'b0, w);
    endtask

    task automatic test_random();
        bit w;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            run_cmd($urandom_range(0, 3), $urandom_range(0, 5), 0, 8'h0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
            if (!(enable && m_fill < RC) && !(m_rd_pend && m_fill > 0)) begin
                if (m_fill < RC) enable = 1'b1;
                else pulse_rd();
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_writes();
        test_full();
        test_round_robin();
        test_hold();
        test_error();
        test_tag();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ddr_ring_sched.md
DDR_RING_SCHED -- requirements
Module: ddr_ring_sched

Interface
REQ-001 SHALL have parameter CHUNK_BYTES, default 4096, bytes per datamover command (BTT); power of two, at most 2^22.
REQ-002 SHALL have parameter RING_CHUNKS, default 16, ring depth in chunks; power of two, 2 to 256.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, DDR byte address of chunk 0.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  level; permits write (S2MM) commands.
REQ-007 rd_req  in  1  pulse; requests one chunk read (MM2S).
REQ-008 S_AXIS_S2MM_CMD_tdata/tvalid/tready  out/out/in  72/1/1  S2MM command stream.
REQ-009 M_AXIS_S2MM_STS_tdata/tvalid/tready  in/in/out  8/1/1  S2MM status stream; tkeep and tlast not used.
REQ-010 S_AXIS_MM2S_CMD_tdata/tvalid/tready  out/out/in  72/1/1  MM2S command stream.
REQ-011 M_AXIS_MM2S_STS_tdata/tvalid/tready  in/in/out  8/1/1  MM2S status stream.
REQ-012 fill  out  9  chunks written and not yet read, 0 to RING_CHUNKS.
REQ-013 full  out  1  fill == RING_CHUNKS.
REQ-014 err  out  1  sticky error flag.

Function
REQ-015 SHALL allow at most one outstanding command across both directions.
REQ-016 FSM states SHALL be IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, ERROR.
REQ-017 Write is pending when enable=1 and full=0; read is pending when rd_pend=1 and fill>0.
REQ-018 IDLE SHALL go to ISSUE_WR or ISSUE_RD on a pending request; if both are pending, the direction not granted last SHALL win (round robin); after reset, write SHALL win first.
REQ-019 rd_req SHALL set rd_pend; rd_pend SHALL clear on the read command handshake; rd_req while rd_pend=1 SHALL be ignored.
REQ-020 ISSUE_x SHALL drive tvalid=1 the cycle after the IDLE decision, hold tdata stable until tready, then go to WAIT_x.
REQ-021 Command tdata SHALL be: [22:0]=CHUNK_BYTES, [23]=1 (INCR), [29:24]=0, [30]=1 (EOF), [31]=0, [63:32]=BASE_ADDR+ptr*CHUNK_BYTES, [67:64]=tag, [71:68]=0.
REQ-022 ptr SHALL be wr_ptr for writes and rd_ptr for reads; each SHALL wrap from RING_CHUNKS-1 to 0.
REQ-023 tag SHALL be a 4-bit counter that increments modulo 16 on every command handshake.
REQ-024 Status tready SHALL be 1 only in the matching WAIT_x state.
REQ-025 A status is good when bit7=1 and bits[6:4]=0.
REQ-026 A good S2MM status SHALL increment wr_ptr and fill, then return to IDLE.
REQ-027 A good MM2S status SHALL increment rd_ptr, decrement fill, then return to IDLE.
REQ-028 A bad status SHALL enter ERROR, set err=1, and block all commands.
REQ-029 ERROR SHALL be exited only by reset.
REQ-030 enable falling during ISSUE_WR or WAIT_WR SHALL NOT abort the write.
REQ-031 fill SHALL never exceed RING_CHUNKS nor underflow.
REQ-032 A status received outside the matching WAIT state is not consumed (tready=0).

Reset
REQ-033 While reset_n=0, the FSM SHALL be in IDLE.
REQ-034 While reset_n=0, all tvalid and tready outputs SHALL be 0.
REQ-035 While reset_n=0, wr_ptr, rd_ptr, fill, tag, rd_pend and err SHALL be 0, and write SHALL hold round-robin priority.
REQ-036 Reset asserted mid-command SHALL drop that command without a status wait.

Configuration
REQ-037 With RING_SCHED_TAG_CHECK_EN defined, status [3:0] not equal to the tag of the outstanding command SHALL be treated as bad (REQ-028).
REQ-038 Without RING_SCHED_TAG_CHECK_EN, status [3:0] SHALL be ignored.

Verification
REQ-039 enable=1, tready=1, good status after 5 cycles -> four write commands with addresses 0x0000, 0x1000, 0x2000, 0x3000, tags 0-3, fill=4.
REQ-040 Writes with no reads -> full=1 at fill=16, no 17th write command; one rd_req plus good status -> fill=15, next write at wr_ptr 0, address 0x0000.
REQ-041 enable=1 and rd_req pulse with fill=3 -> grants alternate read, write, read; read address starts at 0x0000.
REQ-042 S2MM status 0xC0 (SLVERR) -> err=1, FSM stays in ERROR, no further tvalid, fill unchanged.
REQ-043 Macro defined, status tag 5 while tag 4 is outstanding -> err=1; macro undefined -> accepted, fill increments.
REQ-044 cmd tready held 0 for 10 cycles -> tvalid and tdata stable throughout; reset_n pulsed in WAIT_WR -> all outputs at reset values the same cycle.
